// File: rtl/conv_window_gen_pkg.sv
// Shared types, constants and helper functions for the sliding-window generator.
// Latency: n/a. This file has no logic.
// Backpressure: n/a.
package conv_window_gen_pkg;

   // Default configuration. Each instance may override it through its own parameters.
   localparam int DEF_CL_IN  = 9;
   localparam int DEF_KERNEL = 3;
   localparam int DEF_N      = 4;
   localparam int DEF_IMG_W  = 16;
   localparam int DEF_IMG_H  = 16;

   // Widths for the default configuration.
   localparam int WIN_W = DEF_KERNEL * DEF_KERNEL * DEF_N;
   localparam int BUS_W = DEF_CL_IN * WIN_W;

   // Ceiling log2. The result is at least 1, so a counter always has one bit.
   function automatic int CLOG2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

   // Width of one channel's packed window, for any configuration.
   function automatic int win_w(input int k, input int n);
      return k * k * n;
   endfunction

   // Width of the full window bus across all channels, for any configuration.
   function automatic int bus_w(input int cl, input int k, input int n);
      return cl * k * k * n;
   endfunction

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } state_e;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One-row delay line: d_o shows the pixel written DEPTH accepted pixels earlier.
// Latency: read is combinational from the current slot; the slot is overwritten on the same edge.
// Backpressure: none. Advances only when en_i is high.
module conv_window_gen_line_buffer
   import conv_window_gen_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] d_o
);
   localparam int            AW   = CLOG2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] ptr_q;

   // The slot under the pointer holds the oldest pixel. It is read before it is overwritten.
   assign d_o = mem_q[ptr_q];

   // Storage has no reset. Its contents are don't-care until a full row has been written.
   always_ff @(posedge clk_i) begin
      if (en_i) mem_q[ptr_q] <= d_i;
   end

   // Circular pointer. It wraps at DEPTH-1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   ptr_q <= '0;
      else if (en_i) ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
   end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scan to KERNELxKERNEL sliding-window generator (stride 1, no padding) for the CE array.
// Latency: window and en_out are registered one cycle after the edge that accepts the bottom-right pixel.
// Backpressure: none. en_in=0 bubbles freeze all state and hold data2conv.
module conv_window_gen
   import conv_window_gen_pkg::*;
#(
   parameter int CL_IN  = DEF_CL_IN,
   parameter int KERNEL = DEF_KERNEL,
   parameter int N      = DEF_N,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CL_IN*N-1:0]               d_in,
   input  logic                             en_in,
   input  logic                             sof,
   output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
   output logic                             en_out,
   output logic                             frame_done
);
   localparam int            WW       = win_w(KERNEL, N);
   localparam int            BW       = bus_w(CL_IN, KERNEL, N);
   localparam int            CW       = CLOG2(IMG_W);
   localparam int            RW       = CLOG2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_KM1  = CW'(KERNEL - 1);
   localparam logic [RW-1:0] ROW_KM1  = RW'(KERNEL - 1);

   logic [CW-1:0] col_q, col_d, col_eff;
   logic [RW-1:0] row_q, row_d, row_eff;
   state_e        state_q, state_d, state_eff;
   logic          resync, last_pix, stream_now, emit;
   logic [BW-1:0] data2conv_q, win_d;
   logic          en_out_q, frame_done_q;

   // tap[ch][r] is the pixel entering window row r. Row KERNEL-1 is the live input.
   logic [N-1:0] tap  [CL_IN][KERNEL];
   logic [N-1:0] sh_q [CL_IN][KERNEL][KERNEL];
   logic [N-1:0] sh_d [CL_IN][KERNEL][KERNEL];

   // Chain KERNEL-1 row delays per channel. Each delay pushes a row one step further up the window.
   for (genvar ch = 0; ch < CL_IN; ch++) begin : g_ch
      assign tap[ch][KERNEL-1] = d_in[ch*N +: N];
      for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lb
         conv_window_gen_line_buffer #(
            .DEPTH (IMG_W),
            .W     (N)
         ) u_lb (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (en_in),
            .d_i    (tap[ch][KERNEL-1-j]),
            .d_o    (tap[ch][KERNEL-2-j])
         );
      end
   end

   // Resolve the position of the pixel being accepted (sof forces 0,0), then choose the next counters and state.
   always_comb begin
      resync     = en_in && sof;
      col_eff    = resync ? '0 : col_q;
      row_eff    = resync ? '0 : row_q;
      state_eff  = resync ? FILL : state_q;
      last_pix   = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      // The pixel that starts row KERNEL-1 already counts as streaming. For KERNEL=1 this is every frame's first pixel.
      stream_now = (state_eff == STREAM) || ((row_eff == ROW_KM1) && (col_eff == '0));
      emit       = en_in && stream_now && (col_eff >= COL_KM1);
      col_d      = col_q;
      row_d      = row_q;
      state_d    = state_q;
      if (en_in) begin
         if (col_eff == COL_LAST) begin
            col_d = '0;
            row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
         end else begin
            col_d = col_eff + 1'b1;
            row_d = row_eff;
         end
         if (last_pix && (KERNEL > 1)) state_d = FILL;
         else if (stream_now)          state_d = STREAM;
         else                          state_d = FILL;
      end
   end

   // Shift every window row left by one column, bring in the new tap column, and pack the result for the engine.
   always_comb begin
      win_d = '0;
      for (int ch = 0; ch < CL_IN; ch++) begin
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) sh_d[ch][r][c] = sh_q[ch][r][c+1];
            sh_d[ch][r][KERNEL-1] = tap[ch][r];
            for (int c = 0; c < KERNEL; c++) win_d[ch*WW + (r*KERNEL + c)*N +: N] = sh_d[ch][r][c];
         end
      end
   end

   // Column shift registers. Stale contents are flushed by the KERNEL pixels of each row that precede any window.
   always_ff @(posedge clk) begin
      if (en_in) sh_q <= sh_d;
   end

   // Counters, state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q        <= '0;
         row_q        <= '0;
         state_q      <= FILL;
         data2conv_q  <= '0;
         en_out_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         state_q      <= state_d;
         en_out_q     <= emit;
         frame_done_q <= emit && last_pix;
         if (emit) data2conv_q <= win_d;
      end
   end

   assign data2conv  = data2conv_q;
   assign en_out     = en_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 5x5, K=3 single-channel instance and a 5x5, K=1, 4-channel instance.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none. Bubbles are injected through en_in.
module tb_conv_window_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  d_in;
   logic        en_in, sof;
   logic [35:0] data2conv;
   logic        en_out, frame_done;

   logic [15:0] d_in2, data2conv2;
   logic        en_in2, sof2, en_out2, frame_done2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [35:0] win_log [$];

   localparam logic [35:0] FIRST_WIN = 36'hCBA765210;  // {0,1,2,5,6,7,10,11,12}
   localparam logic [35:0] LAST_WIN  = 36'h876321EDC;  // {12,13,14,1,2,3,6,7,8}

   conv_window_gen #(
      .CL_IN(1), .KERNEL(3), .N(4), .IMG_W(5), .IMG_H(5)
   ) dut (
      .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .sof(sof),
      .data2conv(data2conv), .en_out(en_out), .frame_done(frame_done)
   );

   conv_window_gen #(
      .CL_IN(4), .KERNEL(1), .N(4), .IMG_W(5), .IMG_H(5)
   ) dut_k1 (
      .clk(clk), .rst(rst), .d_in(d_in2), .en_in(en_in2), .sof(sof2),
      .data2conv(data2conv2), .en_out(en_out2), .frame_done(frame_done2)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] pix(input int r, input int c);
      return 4'((5*r + c) % 16);
   endfunction

   // Expected window for the bottom-right pixel (r,c). Element rr*3+cc is the pixel at (r-2+rr, c-2+cc).
   function automatic logic [35:0] exp_win(input int r, input int c);
      logic [35:0] w;
      w = '0;
      for (int rr = 0; rr < 3; rr++)
         for (int cc = 0; cc < 3; cc++)
            w[(rr*3 + cc)*4 +: 4] = pix(r - 2 + rr, c - 2 + cc);
      return w;
   endfunction

   // Sends 'n' raster pixels from (0,0) with sof on the first. Outputs are ignored. en_in is left high.
   task automatic send_partial(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         en_in = 1'b1;
         sof   = (k == 0);
         d_in  = pix(k / 5, k % 5);
         @(posedge clk); #1;
      end
   endtask

   // Sends one full 5x5 frame with sof on the first pixel and optional bubbles. Returns tallies for the caller to judge.
   task automatic run_frame(input int bubble_pct, output int nwin, output int nbad,
                            output int nfd, output int first_idx, output int nunstable);
      logic [35:0] prev;
      int idx;
      nwin = 0; nbad = 0; nfd = 0; first_idx = 0; nunstable = 0; idx = 0;
      prev = data2conv;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            for (int b = 0; b < 8; b++) begin
               if ($urandom_range(99) >= bubble_pct) break;
               @(negedge clk);
               en_in = 1'b0;
               sof   = $urandom_range(1);
               d_in  = 4'($urandom);
               @(posedge clk); #1;
               if (en_out !== 1'b0 || frame_done !== 1'b0 || data2conv !== prev) nunstable++;
            end
            @(negedge clk);
            en_in = 1'b1;
            sof   = (r == 0 && c == 0);
            d_in  = pix(r, c);
            @(posedge clk); #1;
            idx++;
            if (en_out !== ((r >= 2) && (c >= 2))) nbad++;
            if (en_out === 1'b1) begin
               nwin++;
               win_log.push_back(data2conv);
               if (first_idx == 0) first_idx = idx;
               if (data2conv !== exp_win(r, c)) nbad++;
            end
            if (frame_done !== (r == 4 && c == 4)) nbad++;
            if (frame_done === 1'b1) nfd++;
            prev = data2conv;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; en_in = 1'b0; sof = 1'b0; d_in = '0;
      en_in2 = 1'b0; sof2 = 1'b0; d_in2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++; if (data2conv !== 36'h0) $display("FAIL reset_data2conv got %h want 0", data2conv); else pass_cnt++;
      total_cnt++; if (en_out !== 1'b0) $display("FAIL reset_en_out got %b want 0", en_out); else pass_cnt++;
      total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else pass_cnt++;
      total_cnt++; if (data2conv2 !== 16'h0) $display("FAIL reset_k1_data got %h want 0", data2conv2); else pass_cnt++;
      total_cnt++; if (en_out2 !== 1'b0) $display("FAIL reset_k1_en_out got %b want 0", en_out2); else pass_cnt++;
      total_cnt++; if (frame_done2 !== 1'b0) $display("FAIL reset_k1_frame_done got %b want 0", frame_done2); else pass_cnt++;
      rst = 1'b1;
   endtask

   task automatic test_basic_fill;
      int nwin, nbad, nfd, first_idx, nuns;
      win_log.delete();
      run_frame(0, nwin, nbad, nfd, first_idx, nuns);
      total_cnt++; if (first_idx !== 13) $display("FAIL basic_first_idx got %0d want 13", first_idx); else pass_cnt++;
      total_cnt++; if (win_log.size() < 1 || win_log[0] !== FIRST_WIN) $display("FAIL basic_first_win got %h want %h", (win_log.size() > 0) ? win_log[0] : 36'h0, FIRST_WIN); else pass_cnt++;
      total_cnt++; if (win_log.size() < 9 || win_log[8] !== LAST_WIN) $display("FAIL basic_last_win got %h want %h", (win_log.size() > 8) ? win_log[8] : 36'h0, LAST_WIN); else pass_cnt++;
      total_cnt++; if (nwin !== 9) $display("FAIL basic_win_count got %0d want 9", nwin); else pass_cnt++;
      total_cnt++; if (nfd !== 1) $display("FAIL basic_frame_done_count got %0d want 1", nfd); else pass_cnt++;
      total_cnt++; if (nbad !== 0) $display("FAIL basic_window_errors got %0d want 0", nbad); else pass_cnt++;
      @(negedge clk); en_in = 1'b0; sof = 1'b0;
   endtask

   task automatic test_bubbles;
      int nwin, nbad, nfd, first_idx, nuns;
      win_log.delete();
      run_frame(40, nwin, nbad, nfd, first_idx, nuns);
      total_cnt++; if (nwin !== 9) $display("FAIL bubble_win_count got %0d want 9", nwin); else pass_cnt++;
      total_cnt++; if (nbad !== 0) $display("FAIL bubble_window_errors got %0d want 0", nbad); else pass_cnt++;
      total_cnt++; if (nfd !== 1) $display("FAIL bubble_frame_done_count got %0d want 1", nfd); else pass_cnt++;
      total_cnt++; if (nuns !== 0) $display("FAIL bubble_hold_violations got %0d want 0", nuns); else pass_cnt++;
      @(negedge clk); en_in = 1'b0; sof = 1'b0;
   endtask

   task automatic test_sof_resync;
      int nwin, nbad, nfd, first_idx, nuns;
      send_partial(17);  // the counters now point at (3,2)
      win_log.delete();
      run_frame(0, nwin, nbad, nfd, first_idx, nuns);
      total_cnt++; if (first_idx !== 13) $display("FAIL sof_first_idx got %0d want 13", first_idx); else pass_cnt++;
      total_cnt++; if (win_log.size() < 1 || win_log[0] !== FIRST_WIN) $display("FAIL sof_first_win got %h want %h", (win_log.size() > 0) ? win_log[0] : 36'h0, FIRST_WIN); else pass_cnt++;
      total_cnt++; if (nbad !== 0 || nwin !== 9) $display("FAIL sof_frame got errors=%0d windows=%0d want 0 and 9", nbad, nwin); else pass_cnt++;
      @(negedge clk); en_in = 1'b0; sof = 1'b0;
   endtask

   task automatic test_async_reset;
      int nwin, nbad, nfd, first_idx, nuns;
      send_partial(13);  // the last pixel sent is (2,2), so its window is now on the outputs
      total_cnt++; if (en_out !== 1'b1 || data2conv !== FIRST_WIN) $display("FAIL areset_pre got en=%b win=%h want 1 %h", en_out, data2conv, FIRST_WIN); else pass_cnt++;
      #1 rst = 1'b0; en_in = 1'b0; sof = 1'b0;
      #1;
      total_cnt++; if (data2conv !== 36'h0) $display("FAIL areset_data2conv got %h want 0", data2conv); else pass_cnt++;
      total_cnt++; if (en_out !== 1'b0 || frame_done !== 1'b0) $display("FAIL areset_flags got en=%b fd=%b want 0 0", en_out, frame_done); else pass_cnt++;
      #1 rst = 1'b1;
      win_log.delete();
      run_frame(0, nwin, nbad, nfd, first_idx, nuns);
      total_cnt++; if (first_idx !== 13 || nwin !== 9) $display("FAIL areset_frame got first=%0d windows=%0d want 13 and 9", first_idx, nwin); else pass_cnt++;
      total_cnt++; if (nbad !== 0 || nfd !== 1) $display("FAIL areset_contents got errors=%0d fd=%0d want 0 and 1", nbad, nfd); else pass_cnt++;
      @(negedge clk); en_in = 1'b0; sof = 1'b0;
   endtask

   task automatic test_back_to_back;
      int nwin_a, nbad_a, nfd_a, fi_a, nu_a;
      int nwin_b, nbad_b, nfd_b, fi_b, nu_b;
      win_log.delete();
      run_frame(0, nwin_a, nbad_a, nfd_a, fi_a, nu_a);
      run_frame(0, nwin_b, nbad_b, nfd_b, fi_b, nu_b);
      total_cnt++; if (win_log.size() !== 18) $display("FAIL b2b_en_out_count got %0d want 18", win_log.size()); else pass_cnt++;
      total_cnt++; if (nfd_a + nfd_b !== 2) $display("FAIL b2b_frame_done_count got %0d want 2", nfd_a + nfd_b); else pass_cnt++;
      total_cnt++; if (win_log.size() < 10 || win_log[9] !== FIRST_WIN) $display("FAIL b2b_tenth_win got %h want %h", (win_log.size() > 9) ? win_log[9] : 36'h0, FIRST_WIN); else pass_cnt++;
      total_cnt++; if (nbad_a + nbad_b !== 0) $display("FAIL b2b_window_errors got %0d want 0", nbad_a + nbad_b); else pass_cnt++;
      @(negedge clk); en_in = 1'b0; sof = 1'b0;
   endtask

   task automatic test_kernel1;
      logic [15:0] v;
      logic [15:0] last_v;
      int acc;
      acc = 0; last_v = '0;
      for (int i = 0; i < 60 && acc < 25; i++) begin
         logic en;
         en = (i % 4 != 3);
         v  = 16'(i*16'h1357 + 16'h0abc);
         @(negedge clk);
         en_in2 = en;
         sof2   = en && (acc == 0);
         d_in2  = v;
         @(posedge clk); #1;
         if (en) begin
            acc++;
            total_cnt++; if (en_out2 !== 1'b1) $display("FAIL k1_en_out pix %0d got %b want 1", acc, en_out2); else pass_cnt++;
            total_cnt++; if (data2conv2 !== v) $display("FAIL k1_data pix %0d got %h want %h", acc, data2conv2, v); else pass_cnt++;
            total_cnt++; if (frame_done2 !== (acc == 25)) $display("FAIL k1_frame_done pix %0d got %b want %b", acc, frame_done2, (acc == 25)); else pass_cnt++;
            last_v = v;
         end else begin
            total_cnt++; if (en_out2 !== 1'b0 || data2conv2 !== last_v) $display("FAIL k1_bubble got en=%b data=%h want 0 %h", en_out2, data2conv2, last_v); else pass_cnt++;
         end
      end
      total_cnt++; if (acc !== 25) $display("FAIL k1_accepted got %0d want 25", acc); else pass_cnt++;
      @(negedge clk); en_in2 = 1'b0; sof2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_bubbles();
      test_sof_resync();
      test_async_reset();
      test_back_to_back();
      test_kernel1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Sliding-window generator that feeds the convolution engine's data2conv/en_in inputs. It accepts a raster-scan pixel stream, one pixel per cycle for CL_IN parallel channels. It buffers KERNEL-1 lines per channel and emits each KERNEL x KERNEL window (stride 1, no padding) packed exactly as the engine consumes it. It sits between the feature-map source and the CE array.

Parameters:
CL_IN, 9, number of parallel input channels (1..64)
KERNEL, 3, window size (1/3/5/7)
N, 4, pixel data width
IMG_W, 16, image width in pixels (>= KERNEL)
IMG_H, 16, image height in rows (>= KERNEL)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
d_in  in  CL_IN*N  one pixel per channel; channel i at [i*N +: N]
en_in  in  1  pixel valid; the pixel is accepted on each clk edge with en_in=1
sof  in  1  start of frame; sampled only when en_in=1; marks pixel (0,0)
data2conv  out  CL_IN*KERNEL*KERNEL*N  window; channel i at [i*K*K*N +: K*K*N]; element e=r*KERNEL+c at [e*N +: N]; r=0 is top (oldest) row, c=0 is leftmost column
en_out  out  1  window valid, one-cycle pulse per window
frame_done  out  1  one-cycle pulse with the last window of the frame

Behaviour:
- Reset (rst=0, asynchronous): data2conv=0, en_out=0, frame_done=0, col=0, row=0, state=FILL. Line-buffer RAM contents are not reset and are don't-care.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on accepted pixels.
  - col wraps to 0 at IMG_W-1 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- sof=1 with en_in=1 forces the accepted pixel to be (0,0), regardless of the counters, and sets state=FILL. sof with en_in=0 is ignored.
- Line buffers: KERNEL-1 per channel, each an IMG_W-deep delay that shifts only on accepted pixels.
  - Column shift registers (KERNEL wide) hold the current KERNEL rows.
  - Window row r=KERNEL-1 is the newest row.
- State machine:
  - FILL: row < KERNEL-1. No windows are emitted. Transition to STREAM on accepting pixel (KERNEL-1, 0).
  - STREAM: a window is emitted for every accepted pixel with col >= KERNEL-1. Transition to FILL after the accepted pixel (IMG_H-1, IMG_W-1), or on sof.
- Latency: en_out and data2conv are registered one cycle after the accepting edge of pixel (row, col). The window's top-left corner is (row-KERNEL+1, col-KERNEL+1).
- Windows per frame = (IMG_H-KERNEL+1)*(IMG_W-KERNEL+1).
- en_in=0 cycles: en_out=0, data2conv holds its last value, no state change. Bubbles of any length are allowed anywhere, including mid-row.
- frame_done is asserted in the same cycle as en_out for the window of pixel (IMG_H-1, IMG_W-1).
- Back-to-back frames: the first pixel of the next frame may arrive on the cycle after the last pixel of the previous frame. The previous frame's last en_out is unaffected.
- KERNEL=1: no line buffers, state stays STREAM, and every accepted pixel yields en_out.
- Reset mid-frame: outputs clear immediately. The next frame restarts in FILL, and no stale window is emitted.
- No backpressure: the downstream CE always accepts.

Decomposition:
- Shared package holds:
  - CLOG2 function
  - width constants: WIN_W = KERNEL*KERNEL*N and BUS_W = CL_IN*WIN_W
  - state encoding: FILL=1'b0, STREAM=1'b1
- Sub-module line_buffer (params DEPTH=IMG_W, W=N): a single-row delay with enable, one instance per channel per buffered row. It uses a circular RAM with a read/write pointer that wraps at DEPTH-1.

Test Plan:
1. Basic fill: CL_IN=1, K=3, N=4, IMG_W=IMG_H=5, pixel=(5*row+col) mod 16, en_in always high, sof on the first pixel.
   - First en_out occurs one cycle after the 13th pixel.
   - Window elements 0..8 = {0,1,2,5,6,7,10,11,12}.
   - 9 windows total; frame_done coincides with window {12,13,14,17 mod 16=1,2,3,6,7,8}.
2. Bubbles: same stream with en_in low on a random 40% of cycles.
   - Window contents and count are identical to test 1.
   - data2conv is stable while en_in=0.
3. sof resync: assert sof with en_in=1 mid-frame at (row 3, col 2).
   - No en_out until 2 rows plus 3 pixels of the new frame are accepted.
   - The first new window equals test 1's first window.
4. Async reset mid-frame: pull rst low at row 2, col 3, for a pulse shorter than a clock.
   - Outputs read 0 immediately.
   - After release plus a sof frame, windows match test 1.
5. Back-to-back frames: two frames with no gap, with sof on each first pixel.
   - 18 en_out pulses and exactly 2 frame_done pulses.
   - The 10th window equals the 1st.
6. KERNEL=1 with CL_IN=4: every accepted pixel produces en_out one cycle later.
   - Channel i of data2conv equals channel i of d_in.
